truck_lane_controller: RTL and testbench
========================================

// Module: truck_lane_controller
// PURPOSE
//  Sequences one truck sprite across the playfield.
//  - Waits a random number of frames, then picks a lane and drives the truck left-to-right.
//  - Adds fixed-point speed once per frame, holds the truck briefly on a player hit, then reschedules.
//  - Drives topLeftX/Y into the square-object stage that feeds offsetX/offsetY/InsideRectangle to the truck bitmap.
// PARAMETERS
//  SCREEN_WIDTH  640  X at/after which truck is off-screen (exit)
//  OBJ_WIDTH     32   sprite width; spawn X = -OBJ_WIDTH
//  LANE_Y0       96   top-left Y of lane 0
//  LANE_PITCH    64   Y distance between lanes (4 lanes)
//  FRAC_BITS     6    fractional bits of position/speed
//  INIT_SPEED    128  initial speed, px/frame * 2^FRAC_BITS (=2.0 px)
//  SPEED_STEP    16   speed added after each completed pass
//  MAX_SPEED     512  speed saturation value (=8.0 px)
//  MIN_DELAY     30   minimum spawn delay, frames
//  HIT_FRAMES    60   freeze duration after collision, frames
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  startOfFrame  in   1   one-cycle pulse per video frame
//  gameEnable    in   1   1 = game running; 0 = return to IDLE
//  collision     in   1   truck/player hit, level (sampled in DRIVE)
//  randomVal     in   8   free-running pseudo-random value
//  topLeftX      out  11  signed integer X of sprite top-left
//  topLeftY      out  11  Y of sprite top-left
//  truckActive   out  1   1 in DRIVE or HIT (sprite visible)
//  truckPassed   out  1   one-cycle pulse when truck exits screen
// BEHAVIOUR
//  Clocking/reset:
//  - Single clock domain; all outputs registered.
//  - reset=1 at a clk edge forces IDLE, and reset takes priority over all inputs:
//    posX=-OBJ_WIDTH<<FRAC_BITS, speed=INIT_SPEED, timer=0, topLeftX=-OBJ_WIDTH,
//    topLeftY=LANE_Y0, truckActive=0, truckPassed=0.
//  - Reset asserted mid-pass aborts the pass immediately; no truckPassed pulse.
//  State update:
//  - States change only on cycles where startOfFrame=1, except gameEnable=0,
//    which forces IDLE on the next edge from any state.
//  - Speed is kept on gameEnable dropping; only reset restores INIT_SPEED.
//  IDLE: gameEnable=1 at startOfFrame -> WAIT, timer=MIN_DELAY+randomVal[5:0].
//  WAIT: each startOfFrame timer-1; at timer==0 on startOfFrame -> DRIVE:
//    - lane=randomVal[7:6]; topLeftY=LANE_Y0+lane*LANE_PITCH
//    - posX=-OBJ_WIDTH<<FRAC_BITS
//  DRIVE: each startOfFrame posX+=speed (posX 11+FRAC_BITS signed, no wrap).
//    - collision=1 on a startOfFrame cycle -> HIT, timer=HIT_FRAMES-1, posX not advanced.
//    - Else if new posX integer >= SCREEN_WIDTH -> WAIT:
//      truckPassed pulses 1 cycle; speed=min(speed+SPEED_STEP, MAX_SPEED);
//      timer reloaded as in IDLE.
//    - Collision and exit in the same frame: collision wins.
//  HIT: position frozen; timer-1 per frame; at 0 -> WAIT with fresh delay.
//    - Speed unchanged; no truckPassed.
//  Outputs:
//  - topLeftX = posX >>> FRAC_BITS (arithmetic).
//  - topLeftX/Y update the cycle after the startOfFrame that changed them.
//  - truckActive high in DRIVE and HIT; low in IDLE and WAIT.
//  - Timer is 8 bits and saturates at 0, never wraps.
//  - Speed arithmetic is done in 10 bits and saturates at MAX_SPEED.
// STRUCTURE
//  Shared package truck_pkg:
//  - truck_state_t enum {IDLE, WAIT, DRIVE, HIT}
//  - NUM_LANES=4, lane index typedef, POS_W = 11+FRAC_BITS
//  Sub-module: truck_frame_timer
//  - 8-bit loadable down-counter, decrements on startOfFrame, zero flag.
//  - Shared by WAIT and HIT.
//  Top level: FSM, position accumulator, speed register.
// TESTING
//  1 reset=1 mid-DRIVE -> next cycle IDLE, truckActive=0, topLeftX=-32, no truckPassed.
//  2 gameEnable=1, randomVal=8'hC5 at spawn -> DRIVE after 30+5=35 frames, lane 3, topLeftY=288.
//  3 DRIVE at speed 128 -> topLeftX -32,-30,-28,...; at X>=640 truckPassed 1 cycle, speed=144.
//  4 collision at X=100 -> HIT, X held 100 for 60 frames, truckActive=1, then WAIT, speed unchanged.
//  5 collision and exit on the same frame -> HIT, no truckPassed.
//  6 after 24 passes -> speed saturates at 512; gameEnable=0 in WAIT -> IDLE next edge.

Source files
------------

// File: rtl/truck_pkg.sv
// Shared types, parameters and helpers for the truck lane sprite sequencer.
package truck_pkg;

    localparam int SCREEN_WIDTH = 640;
    localparam int OBJ_WIDTH    = 32;
    localparam int LANE_Y0      = 96;
    localparam int LANE_PITCH   = 64;
    localparam int FRAC_BITS    = 6;
    localparam int INIT_SPEED   = 128;
    localparam int SPEED_STEP   = 16;
    localparam int MAX_SPEED    = 512;
    localparam int MIN_DELAY    = 30;
    localparam int HIT_FRAMES   = 60;

    localparam int NUM_LANES = 4;
    localparam int POS_W     = 11 + FRAC_BITS;
    localparam int SPEED_W   = 10;
    localparam int TIMER_W   = 8;

    typedef enum logic [1:0] {IDLE, WAIT, DRIVE, HIT} truck_state_t;
    typedef logic [$clog2(NUM_LANES)-1:0] lane_t;

    localparam logic signed [POS_W-1:0] SPAWN_POS =
        POS_W'(-(OBJ_WIDTH * (2 ** FRAC_BITS)));

    function automatic logic [TIMER_W-1:0] spawn_delay(input logic [7:0] rnd);
        return TIMER_W'(MIN_DELAY) + {2'b00, rnd[5:0]};
    endfunction

    function automatic logic [10:0] lane_y(input lane_t lane);
        return 11'(LANE_Y0) + 11'(lane) * 11'(LANE_PITCH);
    endfunction

endpackage

// File: rtl/truck_frame_timer.sv
// Loadable 8-bit frame down-counter, saturating at zero.
module truck_frame_timer
    import truck_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truck_lane_controller.sv
// Truck sprite sequencer: spawn delay, lane pick, fixed-point drive, hit freeze.
module truck_lane_controller
    import truck_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        gameEnable,
    input  logic        collision,
    input  logic [7:0]  randomVal,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        truckActive,
    output logic        truckPassed
);

    truck_state_t              state_q, state_d;
    logic signed [POS_W-1:0]   pos_q, pos_d;
    logic [SPEED_W-1:0]        speed_q, speed_d;
    logic [10:0]               y_q, y_d;
    logic                      passed_q, passed_d;
    logic                      active_q, active_d;

    logic                      tmr_load;
    logic [TIMER_W-1:0]        tmr_val;
    logic                      tmr_dec;
    logic                      tmr_zero;

    logic signed [POS_W-1:0]   new_pos;
    logic signed [10:0]        new_x;
    logic                      exit_hit;
    logic [SPEED_W-1:0]        speed_inc;
    logic [SPEED_W-1:0]        speed_sat;

    truck_frame_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign new_pos   = pos_q + $signed({{(POS_W-SPEED_W){1'b0}}, speed_q});
    assign new_x     = new_pos[POS_W-1:FRAC_BITS];
    assign exit_hit  = (new_x >= $signed(11'(SCREEN_WIDTH)));
    assign speed_inc = speed_q + SPEED_W'(SPEED_STEP);
    assign speed_sat = (speed_inc > SPEED_W'(MAX_SPEED)) ?
                       SPEED_W'(MAX_SPEED) : speed_inc;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        speed_d  = speed_q;
        y_d      = y_q;
        passed_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = spawn_delay(randomVal);
        tmr_dec  = 1'b0;

        if (!gameEnable) begin
            state_d = IDLE;
        end else if (startOfFrame) begin
            unique case (state_q)
                IDLE: begin
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                end
                WAIT: begin
                    if (tmr_zero) begin
                        state_d = DRIVE;
                        y_d     = lane_y(randomVal[7:6]);
                        pos_d   = SPAWN_POS;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                DRIVE: begin
                    // A hit in the exit frame wins: no advance, no pass.
                    if (collision) begin
                        state_d  = HIT;
                        tmr_load = 1'b1;
                        tmr_val  = TIMER_W'(HIT_FRAMES - 1);
                    end else begin
                        pos_d = new_pos;
                        if (exit_hit) begin
                            state_d  = WAIT;
                            passed_d = 1'b1;
                            speed_d  = speed_sat;
                            tmr_load = 1'b1;
                        end
                    end
                end
                HIT: begin
                    if (tmr_zero) begin
                        state_d  = WAIT;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        active_d = (state_d == DRIVE) || (state_d == HIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pos_q    <= SPAWN_POS;
            speed_q  <= SPEED_W'(INIT_SPEED);
            y_q      <= 11'(LANE_Y0);
            passed_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            speed_q  <= speed_d;
            y_q      <= y_d;
            passed_q <= passed_d;
            active_q <= active_d;
        end
    end

    assign topLeftX    = pos_q[POS_W-1:FRAC_BITS];
    assign topLeftY    = y_q;
    assign truckActive = active_q;
    assign truckPassed = passed_q;

endmodule

// File: tb/tb_truck_lane_controller.sv
// Directed bench for truck_lane_controller with a per-cycle reference model.
module tb_truck_lane_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        gameEnable;
    logic        collision;
    logic [7:0]  randomVal;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        truckActive;
    logic        truckPassed;

    truck_lane_controller dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .gameEnable   (gameEnable),
        .collision    (collision),
        .randomVal    (randomVal),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .truckActive  (truckActive),
        .truckPassed  (truckPassed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    bit saw_pass;

    typedef enum {M_IDLE, M_WAIT, M_DRIVE, M_HIT} mmode_t;
    mmode_t m_mode;
    int m_pos, m_speed, m_timer, m_y, m_x;
    bit m_passed;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Fixed-point position in 1/64 px; pixel = floor(pos / 64).
    function automatic int px(input int p);
        return (p >= 0) ? p / 64 : -((-p + 63) / 64);
    endfunction

    task automatic model_step();
        m_passed = 1'b0;
        if (reset) begin
            m_mode  = M_IDLE;
            m_pos   = -32 * 64;
            m_speed = 128;
            m_timer = 0;
            m_y     = 96;
        end else if (!gameEnable) begin
            m_mode = M_IDLE;
        end else if (startOfFrame) begin
            case (m_mode)
                M_IDLE: begin
                    m_mode  = M_WAIT;
                    m_timer = 30 + (randomVal % 64);
                end
                M_WAIT: begin
                    if (m_timer == 0) begin
                        m_mode = M_DRIVE;
                        m_y    = 96 + 64 * (randomVal / 64);
                        m_pos  = -32 * 64;
                    end else begin
                        m_timer = m_timer - 1;
                    end
                end
                M_DRIVE: begin
                    if (collision) begin
                        m_mode  = M_HIT;
                        m_timer = 59;
                    end else begin
                        m_pos = m_pos + m_speed;
                        if (px(m_pos) >= 640) begin
                            m_mode   = M_WAIT;
                            m_passed = 1'b1;
                            m_speed  = (m_speed + 16 > 512) ? 512 : m_speed + 16;
                            m_timer  = 30 + (randomVal % 64);
                        end
                    end
                end
                default: begin
                    if (m_timer == 0) begin
                        m_mode  = M_WAIT;
                        m_timer = 30 + (randomVal % 64);
                    end else begin
                        m_timer = m_timer - 1;
                    end
                end
            endcase
        end
        m_x = px(m_pos);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_x", int'($signed(topLeftX)), m_x);
            check("cmp_y", int'(topLeftY), m_y);
            check("cmp_active", int'(truckActive),
                  int'(m_mode == M_DRIVE || m_mode == M_HIT));
            check("cmp_passed", int'(truckPassed), int'(m_passed));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic frame(input bit c);
        startOfFrame = 1'b1;
        collision    = c;
        tick();
        saw_pass     = saw_pass | truckPassed;
        startOfFrame = 1'b0;
        collision    = 1'b0;
        tick();
    endtask

    task automatic wait_spawn(output int n);
        n = 0;
        while (!truckActive && n < 200) begin
            frame(1'b0);
            n++;
        end
        check("spawn_timeout", int'(truckActive), 1);
    endtask

    task automatic drive_until_pass(output int n);
        n = 0;
        saw_pass = 1'b0;
        while (!saw_pass && n < 2000) begin
            frame(1'b0);
            n++;
        end
        check("pass_timeout", int'(saw_pass), 1);
    endtask

    int n;

    initial begin
        reset        = 1'b1;
        gameEnable   = 1'b0;
        startOfFrame = 1'b0;
        collision    = 1'b0;
        randomVal    = 8'hC5;
        saw_pass     = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_x", int'($signed(topLeftX)), -32);
        check("rst_y", int'(topLeftY), 96);
        check("rst_active", int'(truckActive), 0);
        check("rst_passed", int'(truckPassed), 0);

        // Spawn with 8'hC5: 35 wait frames, lane 3.
        reset      = 1'b0;
        gameEnable = 1'b1;
        frame(1'b0);
        wait_spawn(n);
        check("wait_frames", n - 1, 35);
        check("lane3_y", int'(topLeftY), 288);
        check("spawn_x", int'($signed(topLeftX)), -32);

        frame(1'b0);
        check("step1_x", int'($signed(topLeftX)), -30);
        frame(1'b0);
        check("step2_x", int'($signed(topLeftX)), -28);
        for (int i = 0; i < 64; i++) frame(1'b0);
        check("pre_hit_x", int'($signed(topLeftX)), 100);

        // Hit freezes X for 60 frames.
        frame(1'b1);
        check("hit_active", int'(truckActive), 1);
        check("hit_x", int'($signed(topLeftX)), 100);
        for (int i = 0; i < 59; i++) begin
            frame(1'b0);
            check("hold_x", int'($signed(topLeftX)), 100);
            check("hold_active", int'(truckActive), 1);
        end
        frame(1'b0);
        check("hit_done", int'(truckActive), 0);

        // Full pass at unchanged speed 128: 336 frames.
        wait_spawn(n);
        drive_until_pass(n);
        check("pass_frames_128", n, 336);
        check("pass_inactive", int'(truckActive), 0);
        check("pulse_width", int'(truckPassed), 0);

        // Speed now 144.
        wait_spawn(n);
        for (int i = 0; i < 4; i++) frame(1'b0);
        check("speed144_x", int'($signed(topLeftX)), -23);

        // Collision on the exit frame.
        saw_pass = 1'b0;
        for (int i = 0; i < 294; i++) frame(1'b0);
        check("pre_exit_x", int'($signed(topLeftX)), 638);
        frame(1'b1);
        check("coll_exit_pass", int'(saw_pass), 0);
        check("coll_exit_active", int'(truckActive), 1);
        check("coll_exit_x", int'($signed(topLeftX)), 638);
        n = 0;
        while (truckActive && n < 100) begin
            frame(1'b0);
            n++;
        end
        check("hit_frames", n, 60);

        // Saturate speed at 512 over further passes.
        for (int p = 0; p < 24; p++) begin
            randomVal = 8'($urandom_range(0, 255));
            wait_spawn(n);
            drive_until_pass(n);
        end
        check("pass_frames_512", n, 84);

        // gameEnable drop in WAIT, speed retained.
        gameEnable = 1'b0;
        tick();
        check("disable_active", int'(truckActive), 0);
        for (int i = 0; i < 3; i++) frame(1'b0);
        gameEnable = 1'b1;
        randomVal  = 8'hC5;
        frame(1'b0);
        wait_spawn(n);
        check("reenable_wait", n - 1, 35);
        frame(1'b0);
        check("speed512_x", int'($signed(topLeftX)), -24);

        // Reset mid-drive.
        for (int i = 0; i < 3; i++) frame(1'b0);
        reset = 1'b1;
        tick();
        check("midrst_x", int'($signed(topLeftX)), -32);
        check("midrst_active", int'(truckActive), 0);
        check("midrst_passed", int'(truckPassed), 0);
        reset = 1'b0;
        frame(1'b0);
        wait_spawn(n);
        frame(1'b0);
        check("speed_restored_x", int'($signed(topLeftX)), -30);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
